// File: rtl/mem_req_pkg.sv
// mem_req_pkg
// Shared definitions for the memory requester: FSM state encoding, the
// memory address/data widths, the highest legal word address and a helper
// that classifies an address as in range.
package mem_req_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  localparam logic [MEM_ADDR_W-1:0] MEM_LAST_ADDR = 16'd256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  function automatic logic addr_in_range(input logic [MEM_ADDR_W-1:0] addr);
    return (addr <= MEM_LAST_ADDR);
  endfunction

endpackage

// File: rtl/mem_requester.sv
// mem_requester
// Initiator-side port for the 16-bit word-addressed main memory. Accepts one
// read or write request at a time over a valid/ready handshake, drives the
// memory address/data/write-enable, absorbs the memory's one-cycle registered
// read latency and returns the result on a valid/ready response channel.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_write/addr/wdata    request: 1 = store, word address, store data
//   resp_valid/resp_ready   response handshake
//   resp_write/rdata/err    response: echoed op, load data (0 for stores),
//                           out-of-range flag
//   mem_address/data_in/    memory Address, DataIn, MemWrite
//   mem_write
//   mem_val                 memory MemVal (valid the cycle after sampling)
//
// Configuration
//   MEM_REQ_BOUNDS_CHECK_EN  when defined, requests above MEM_LAST_ADDR are
//                            answered immediately with resp_err=1 and never
//                            reach the memory. Otherwise resp_err stays 0 and
//                            every request is issued.
module mem_requester
  import mem_req_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_write,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_in,
  output logic        mem_write,
  input  logic [15:0] mem_val
);

  state_e      state_q, state_d;
  logic [15:0] mem_address_q, mem_address_d;
  logic [15:0] mem_data_in_q, mem_data_in_d;
  logic        mem_write_q, mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_write_q, resp_write_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        req_oob;

`ifdef MEM_REQ_BOUNDS_CHECK_EN
  assign req_oob = !addr_in_range(req_addr);
`else
  assign req_oob = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_write_d   = mem_write_q;
    resp_valid_d  = resp_valid_q;
    resp_write_d  = resp_write_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_oob) begin
            // Out-of-range request: answer at once, memory left untouched.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 16'd0;
            resp_write_d = req_write;
            state_d      = RESP;
          end else begin
            mem_address_d = req_addr;
            mem_data_in_d = req_wdata;
            mem_write_d   = req_write;
            state_d       = ISSUE;
          end
        end
      end

      ISSUE: begin
        // The memory samples address/data/write at the end of this cycle.
        mem_write_d = 1'b0;
        if (mem_write_q) begin
          resp_valid_d = 1'b1;
          resp_write_d = 1'b1;
          resp_rdata_d = 16'd0;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // Registered read data is now on mem_val.
        resp_valid_d = 1'b1;
        resp_write_d = 1'b0;
        resp_rdata_d = mem_val;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_address_q <= 16'd0;
      mem_data_in_q <= 16'd0;
      mem_write_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_write_q  <= 1'b0;
      resp_rdata_q  <= 16'd0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_write_q   <= mem_write_d;
      resp_valid_q  <= resp_valid_d;
      resp_write_q  <= resp_write_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_write  = resp_write_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  // Gated by reset so a store caught in ISSUE never reaches the memory.
  assign mem_write   = mem_write_q & ~reset;

endmodule

// File: tb/tb_mem_requester.sv
module tb_mem_requester;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_write;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_write;
  logic [15:0] mem_val;

  int tests = 0;
  int fails = 0;
  int overlap_cnt = 0;

  mem_requester dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_write  (resp_write),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_write   (mem_write),
    .mem_val     (mem_val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: registered read, synchronous write. Index wraps at 512 so
  // addresses above the legal range still land somewhere readable.
  logic [15:0] mem [0:511];
  logic        mem_init;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 16'h0000;
      for (int i = 0; i < 4; i++) mem[i] <= 16'hA000 + 16'(i);
      mem[50]  <= 16'h00FF;
      mem[100] <= 16'h1111;
      mem[256] <= 16'h5A5A;
      mem[300] <= 16'h3C3C;
    end else if (mem_write) begin
      mem[mem_address[8:0]] <= mem_data_in;
    end
    mem_val <= mem[mem_address[8:0]];
  end

  always @(negedge clock) begin
    if (!reset && req_ready && resp_valid) overlap_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction. lat = edges after the accepting edge until
  // resp_valid is seen; pulses = cycles with mem_write high before that.
  task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                     output logic [15:0] rdata, output logic rwr, output logic rerr,
                     output int lat, output int pulses, output logic [15:0] paddr);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    lat    = 0;
    pulses = 0;
    paddr  = 16'd0;
    while (!resp_valid && lat < 10) begin
      if (mem_write) begin
        pulses++;
        paddr = mem_address;
      end
      step();
      lat++;
    end
    rdata = resp_rdata;
    rwr   = resp_write;
    rerr  = resp_err;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_valid_cleared", 32'(resp_valid), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_write;
    logic        exp_err;
    int          exp_lat;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [15:0] rd, pa;
    logic        rw, re;
    int          lat, pulses;
    int          cyc, nacc, nresp;
    int          t_resp [4];
    logic [15:0] d_resp [4];
    logic        acc;

    // Latency: stores 1, loads 2, rejected out-of-range requests 0
    // (response is visible right after the accepting edge).
    vecs[0] = '{1'b1, 16'd40,  16'h1234, 16'h0000, 1'b1, 1'b0, 1, 1};
    vecs[1] = '{1'b0, 16'd40,  16'h0000, 16'h1234, 1'b0, 1'b0, 2, 0};
    vecs[2] = '{1'b1, 16'd7,   16'h00AB, 16'h0000, 1'b1, 1'b0, 1, 1};
    vecs[3] = '{1'b0, 16'd7,   16'h0000, 16'h00AB, 1'b0, 1'b0, 2, 0};
    vecs[4] = '{1'b0, 16'd256, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 2, 0};
`ifdef MEM_REQ_BOUNDS_CHECK_EN
    vecs[5] = '{1'b0, 16'd300, 16'h0000, 16'h0000, 1'b0, 1'b1, 0, 0};
    vecs[6] = '{1'b1, 16'd257, 16'h7777, 16'h0000, 1'b1, 1'b1, 0, 0};
`else
    vecs[5] = '{1'b0, 16'd300, 16'h0000, 16'h3C3C, 1'b0, 1'b0, 2, 0};
    vecs[6] = '{1'b1, 16'd257, 16'h7777, 16'h0000, 1'b1, 1'b0, 1, 1};
`endif

    reset      = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 16'd0;
    req_wdata  = 16'd0;
    resp_ready = 1'b0;
    step();
    step();
    step();
    mem_init = 1'b0;
    reset    = 1'b0;

    check("rst_req_ready",   32'(req_ready),   32'd1);
    check("rst_resp_valid",  32'(resp_valid),  32'd0);
    check("rst_resp_write",  32'(resp_write),  32'd0);
    check("rst_resp_rdata",  32'(resp_rdata),  32'd0);
    check("rst_resp_err",    32'(resp_err),    32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_data_in", 32'(mem_data_in), 32'd0);
    check("rst_mem_write",   32'(mem_write),   32'd0);

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, rw, re, lat, pulses, pa);
      check($sformatf("v%0d_rdata", i),  32'(rd),     32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_write", i),  32'(rw),     32'(vecs[i].exp_write));
      check($sformatf("v%0d_err", i),    32'(re),     32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i),    32'(lat),    32'(vecs[i].exp_lat));
      check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
      if (vecs[i].exp_pulses != 0)
        check($sformatf("v%0d_waddr", i), 32'(pa), 32'(vecs[i].addr));
    end

    // Back-pressure on a load of addr 50, with a competing store presented.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'd50;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      step();
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd2);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'd50;
    req_wdata = 16'hDEAD;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_resp_valid", c), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_rdata", c),      32'(resp_rdata), 32'h00FF);
      check($sformatf("bp%0d_req_ready", c),  32'(req_ready),  32'd0);
      check($sformatf("bp%0d_mem_write", c),  32'(mem_write),  32'd0);
      step();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_released", 32'(resp_valid), 32'd0);
    txn(1'b0, 16'd50, 16'h0000, rd, rw, re, lat, pulses, pa);
    check("bp_store_ignored", 32'(rd), 32'h00FF);

    // Back-to-back loads of addrs 0..3, req_valid held, resp_ready tied high.
    resp_ready = 1'b1;
    req_write  = 1'b0;
    req_addr   = 16'd0;
    req_valid  = 1'b1;
    cyc = 0; nacc = 0; nresp = 0;
    while (nresp < 4 && cyc < 40) begin
      acc = req_ready && req_valid;
      step();
      cyc++;
      if (acc) begin
        nacc++;
        req_addr = 16'(nacc);
        if (nacc == 4) req_valid = 1'b0;
      end
      if (resp_valid) begin
        t_resp[nresp] = cyc;
        d_resp[nresp] = resp_rdata;
        nresp++;
      end
    end
    resp_ready = 1'b0;
    check("b2b_count", 32'(nresp), 32'd4);
    if (nresp == 4) begin
      check("b2b_first_lat", 32'(t_resp[0]), 32'd3);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b2b%0d_rdata", i), 32'(d_resp[i]), 32'hA000 + 32'(i));
        if (i > 0) check($sformatf("b2b%0d_gap", i), 32'(t_resp[i] - t_resp[i-1]), 32'd4);
      end
    end
    step();

    // Reset during the ISSUE cycle of a store of 0xBEEF to addr 100.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'd100;
    req_wdata = 16'hBEEF;
    step();
    req_valid = 1'b0;
    reset     = 1'b1;
    check("rst_issue_mem_write", 32'(mem_write), 32'd0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rst_issue_no_resp%0d", c), 32'(resp_valid), 32'd0);
      step();
    end
    txn(1'b0, 16'd100, 16'h0000, rd, rw, re, lat, pulses, pa);
    check("rst_issue_not_written", 32'(rd), 32'h1111);

    check("no_ready_valid_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
